// File: rtl/rv32i_multicycle_ctrl.sv
// rv32i_multicycle_ctrl: multi-cycle RV32I control path.
// Owns PC, IR and old-PC. Sequences fetch/decode/execute/memory/writeback over a
// single shared req/ready memory port, and raises traps for misaligned fetch,
// misaligned data, bus timeout and illegal opcodes.
// Optional: define PERF_COUNTERS_EN to add cycle_count/instret_count outputs.
module rv32i_multicycle_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] old_pc,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  input  logic        branch_taken,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic [31:0] load_data,
  output logic        halted,
  output logic [1:0]  trap_cause
`ifdef PERF_COUNTERS_EN
  ,
  output logic [63:0] cycle_count,
  output logic [63:0] instret_count
`endif
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [1:0]  cause_nxt;
  logic [31:0] addr_q;
  logic [7:0]  wait_cnt;

  // Opcode decode from the instruction register
  logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
  logic known, misal;
  assign is_lui    = instr[6:0] == 7'b0110111;
  assign is_auipc  = instr[6:0] == 7'b0010111;
  assign is_jal    = instr[6:0] == 7'b1101111;
  assign is_jalr   = instr[6:0] == 7'b1100111;
  assign is_branch = instr[6:0] == 7'b1100011;
  assign is_load   = instr[6:0] == 7'b0000011;
  assign is_store  = instr[6:0] == 7'b0100011;
  assign is_opimm  = instr[6:0] == 7'b0010011;
  assign is_op     = instr[6:0] == 7'b0110011;

  // Loads allow B/H/W/BU/HU, stores B/H/W; other funct3 codes are illegal.
  assign known = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_opimm | is_op |
                 (is_load  & (instr[13:12] != 2'b11) & !(instr[14] & instr[13])) |
                 (is_store & (instr[13:12] != 2'b11) & !instr[14]);

  assign misal = (instr[13:12] == 2'b01 && addr_q[0]) ||
                 (instr[13:12] == 2'b10 && addr_q[1:0] != 2'b00);

  // a=old_pc for PC-relative targets; b=imm everywhere except register-register ops
  // (branch targets are old_pc+imm; the compare itself arrives on branch_taken).
  assign alu_src_a = is_auipc | is_jal | is_branch;
  assign alu_src_b = !is_op;
  assign wb_sel    = is_lui ? 2'b00 : (is_jal | is_jalr) ? 2'b10 : is_load ? 2'b11 : 2'b01;
  assign halted    = state == TRAP;

  // Load lane extraction with sign/zero extension
  logic [31:0] rd_sh, ld_ext;
  always_comb begin
    rd_sh = mem_rdata >> {addr_q[1:0], 3'b000};
    case (instr[14:12])
      3'b000:  ld_ext = {{24{rd_sh[7]}}, rd_sh[7:0]};
      3'b001:  ld_ext = {{16{rd_sh[15]}}, rd_sh[15:0]};
      3'b100:  ld_ext = {24'b0, rd_sh[7:0]};
      3'b101:  ld_ext = {16'b0, rd_sh[15:0]};
      default: ld_ext = rd_sh;
    endcase
  end

  // Next state, trap cause and bus/regfile strobes
  always_comb begin
    state_nxt = state;
    cause_nxt = trap_cause;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_wstrb = 4'b0000;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    reg_write = 1'b0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        if (pc[1:0] != 2'b00) begin
          state_nxt = TRAP;
          cause_nxt = 2'b01;
        end else begin
          mem_req  = 1'b1;
          mem_addr = {pc[31:2], 2'b00};
          if (mem_ready) state_nxt = DECODE;
          else if (wait_cnt == TO_LAST) begin
            state_nxt = TRAP;
            cause_nxt = 2'b11;
          end
        end
      end
      DECODE: begin
        if (known) state_nxt = EXEC;
        else begin
          state_nxt = TRAP;
          cause_nxt = 2'b11;
        end
      end
      EXEC: begin
        if (is_branch) state_nxt = FETCH;
        else if (is_load | is_store) state_nxt = MEM;
        else state_nxt = WB;
      end
      MEM: begin
        // Misaligned data is trapped before any request reaches the bus.
        if (misal) begin
          state_nxt = TRAP;
          cause_nxt = 2'b10;
        end else begin
          mem_req  = 1'b1;
          mem_addr = {addr_q[31:2], 2'b00};
          if (is_store) begin
            mem_we = 1'b1;
            case (instr[13:12])
              2'b00: begin
                mem_wstrb = 4'b0001 << addr_q[1:0];
                mem_wdata = {24'b0, rs2_data[7:0]} << {addr_q[1:0], 3'b000};
              end
              2'b01: begin
                mem_wstrb = 4'b0011 << addr_q[1:0];
                mem_wdata = {16'b0, rs2_data[15:0]} << {addr_q[1:0], 3'b000};
              end
              default: begin
                mem_wstrb = 4'b1111;
                mem_wdata = rs2_data;
              end
            endcase
          end
          if (mem_ready) state_nxt = is_load ? WB : FETCH;
          else if (wait_cnt == TO_LAST) begin
            state_nxt = TRAP;
            cause_nxt = 2'b11;
          end
        end
      end
      WB: begin
        reg_write = 1'b1;
        state_nxt = FETCH;
      end
      TRAP: ;
      default: state_nxt = IDLE;
    endcase
  end

  // State, architectural registers and bus wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      instr      <= 32'h0;
      old_pc     <= 32'h0;
      addr_q     <= 32'h0;
      load_data  <= 32'h0;
      trap_cause <= 2'b00;
      wait_cnt   <= 8'h0;
    end else begin
      state      <= state_nxt;
      trap_cause <= cause_nxt;
      // Any state change clears the counter, so each FETCH/MEM entry starts at 0.
      if (state_nxt != state) wait_cnt <= 8'h0;
      else if (mem_req) wait_cnt <= wait_cnt + 8'h1;
      case (state)
        FETCH: if (mem_req && mem_ready) begin
          instr  <= mem_rdata;
          old_pc <= pc;
          pc     <= pc + 32'd4;
        end
        EXEC: begin
          if (is_branch && branch_taken) pc <= alu_result;
          if (is_jal || is_jalr) pc <= alu_result & ~32'h1;
          if (is_load || is_store) addr_q <= alu_result;
        end
        MEM: if (mem_req && mem_ready && is_load) load_data <= ld_ext;
        default: ;
      endcase
    end
  end

`ifdef PERF_COUNTERS_EN
  // Free-running cycle and retired-instruction counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count   <= 64'h0;
      instret_count <= 64'h0;
    end else begin
      if (state != TRAP) cycle_count <= cycle_count + 64'h1;
      if ((state == WB) || (state == EXEC && is_branch) ||
          (state == MEM && is_store && mem_req && mem_ready))
        instret_count <= instret_count + 64'h1;
    end
  end
`endif

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Directed bench for rv32i_multicycle_ctrl: table of non-memory instructions plus
// hand-written load/store, trap, timeout and reset sequences.
module tb_rv32i_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic [31:0] instr, pc, old_pc, alu_result, rs2_data;
  logic        branch_taken, alu_src_a, alu_src_b, reg_write;
  logic [1:0]  wb_sel;
  logic [31:0] load_data;
  logic        halted;
  logic [1:0]  trap_cause;
`ifdef PERF_COUNTERS_EN
  logic [63:0] cycle_count, instret_count;
`endif

  int n_pass = 0;
  int n_total = 0;

  rv32i_multicycle_ctrl #(.RESET_PC(32'h100), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .instr(instr), .pc(pc), .old_pc(old_pc), .alu_result(alu_result),
    .rs2_data(rs2_data), .branch_taken(branch_taken), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .reg_write(reg_write), .wb_sel(wb_sel),
    .load_data(load_data), .halted(halted), .trap_cause(trap_cause)
`ifdef PERF_COUNTERS_EN
    , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] alu;
    logic        tk;
    int          dly;
    logic        sa;
    logic        sb;
    logic        wb;
    logic [1:0]  sel;
    logic [31:0] npc;
  } vec_t;

  vec_t vt[8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic reset_dut;
    reset = 1'b1;
    mem_ready = 1'b0;
    #2;
    chk("rst_pc", pc, 32'h100);
    chk("rst_instr", instr, 32'h0);
    chk("rst_old_pc", old_pc, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_cause", trap_cause, 2'b00);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_rw", reg_write, 1'b0);
    tick;
    reset = 1'b0;
    #1;
    chk("idle_req", mem_req, 1'b0);
    tick;
  endtask

  // Entered in FETCH; returns in DECODE after the instruction is accepted.
  task automatic fetch(input logic [31:0] a, input logic [31:0] w, input int dly);
    for (int i = 0; i <= dly; i++) begin
      mem_ready = (i == dly);
      mem_rdata = (i == dly) ? w : 32'hDEAD_BEEF;
      #1;
      chk("fetch_req", mem_req, 1'b1);
      chk("fetch_addr", mem_addr, a);
      chk("fetch_we", mem_we, 1'b0);
      tick;
    end
    mem_ready = 1'b0;
    chk("instr", instr, w);
    chk("old_pc", old_pc, a);
    chk("pc_inc", pc, a + 32'd4);
  endtask

  task automatic to_exec(input logic [31:0] a, input logic [31:0] w);
    fetch(a, w, 0);
    chk("dec_req", mem_req, 1'b0);
    tick;
  endtask

  task automatic do_load(input logic [31:0] pa, input logic [31:0] ins, input logic [31:0] ea,
                         input logic [31:0] rdata, input logic [31:0] exp);
    to_exec(pa, ins);
    alu_result = ea;
    #1;
    chk("ld_src_b", alu_src_b, 1'b1);
    tick;
    mem_ready = 1'b1;
    mem_rdata = rdata;
    #1;
    chk("ld_req", mem_req, 1'b1);
    chk("ld_addr", mem_addr, {ea[31:2], 2'b00});
    chk("ld_we", mem_we, 1'b0);
    tick;
    mem_ready = 1'b0;
    chk("load_data", load_data, exp);
    chk("ld_rw", reg_write, 1'b1);
    chk("ld_sel", wb_sel, 2'b11);
    tick;
    chk("ld_next_req", mem_req, 1'b1);
    chk("ld_rw_off", reg_write, 1'b0);
  endtask

  task automatic do_store(input logic [31:0] pa, input logic [31:0] ins, input logic [31:0] ea,
                          input logic [31:0] rs2, input logic [3:0] strb,
                          input logic [31:0] wd);
    to_exec(pa, ins);
    alu_result = ea;
    rs2_data = rs2;
    tick;
    mem_ready = 1'b1;
    #1;
    chk("st_req", mem_req, 1'b1);
    chk("st_we", mem_we, 1'b1);
    chk("st_addr", mem_addr, {ea[31:2], 2'b00});
    chk("st_wstrb", mem_wstrb, strb);
    chk("st_wdata", mem_wdata, wd);
    tick;
    mem_ready = 1'b0;
    chk("st_next_req", mem_req, 1'b1);
    chk("st_next_addr", mem_addr, pa + 32'd4);
    chk("st_rw", reg_write, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    vt[0] = '{32'h0050_0093, 32'h0000_0005, 1'b0, 3, 1'b0, 1'b1, 1'b1, 2'b01, 32'h104}; // ADDI, 3 wait
    vt[1] = '{32'h0020_81B3, 32'h0000_0007, 1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b01, 32'h108}; // ADD
    vt[2] = '{32'h1234_52B7, 32'h0000_0000, 1'b0, 1, 1'b0, 1'b1, 1'b1, 2'b00, 32'h10C}; // LUI
    vt[3] = '{32'h0000_1217, 32'h0000_110C, 1'b0, 0, 1'b1, 1'b1, 1'b1, 2'b01, 32'h110}; // AUIPC
    vt[4] = '{32'h0000_0063, 32'h0000_0200, 1'b0, 0, 1'b1, 1'b1, 1'b0, 2'b01, 32'h114}; // BEQ nt
    vt[5] = '{32'h0000_0063, 32'h0000_0040, 1'b1, 0, 1'b1, 1'b1, 1'b0, 2'b01, 32'h040}; // BEQ t
    vt[6] = '{32'h0080_00EF, 32'h0000_0049, 1'b0, 0, 1'b1, 1'b1, 1'b1, 2'b10, 32'h048}; // JAL
    vt[7] = '{32'h0001_00E7, 32'h0000_0060, 1'b0, 0, 1'b0, 1'b1, 1'b1, 2'b10, 32'h060}; // JALR

    mem_rdata = 32'h0; mem_ready = 1'b0; alu_result = 32'h0;
    rs2_data = 32'h0; branch_taken = 1'b0;
    reset_dut;

    a = 32'h100;
    for (int i = 0; i < 8; i++) begin
      fetch(a, vt[i].ins, vt[i].dly);
      chk("dec_req", mem_req, 1'b0);
      tick;
      alu_result = vt[i].alu;
      branch_taken = vt[i].tk;
      #1;
      chk("src_a", alu_src_a, vt[i].sa);
      chk("src_b", alu_src_b, vt[i].sb);
      chk("exec_rw", reg_write, 1'b0);
      tick;
      branch_taken = 1'b0;
      if (vt[i].wb) begin
        chk("wb_rw", reg_write, 1'b1);
        chk("wb_sel", wb_sel, vt[i].sel);
        tick;
      end
      chk("next_req", mem_req, 1'b1);
      chk("rw_off", reg_write, 1'b0);
      chk("next_pc", pc, vt[i].npc);
      chk("not_halted", halted, 1'b0);
      a = vt[i].npc;
    end

    // Loads and stores with lane handling
    do_load(32'h060, 32'h0001_0083, 32'h203, 32'h80AA_BBCC, 32'hFFFF_FF80); // LB
    do_load(32'h064, 32'h0001_4083, 32'h203, 32'h80AA_BBCC, 32'h0000_0080); // LBU
    do_load(32'h068, 32'h0001_5083, 32'h202, 32'hBEEF_1234, 32'h0000_BEEF); // LHU
    do_load(32'h06C, 32'h0001_1083, 32'h200, 32'h0000_8001, 32'hFFFF_8001); // LH
    do_store(32'h070, 32'h0020_9023, 32'h206, 32'h0000_1234, 4'b1100, 32'h1234_0000); // SH
    do_store(32'h074, 32'h0020_8023, 32'h201, 32'h0000_00AB, 4'b0010, 32'h0000_AB00); // SB

    // JALR to an odd target: bit 0 cleared, bit 1 traps on the next fetch
    to_exec(32'h078, 32'h0001_00E7);
    alu_result = 32'h043;
    tick;
    chk("jalr_rw", reg_write, 1'b1);
    chk("jalr_sel", wb_sel, 2'b10);
    chk("jalr_pc", pc, 32'h042);
    tick;
    chk("misfetch_noreq", mem_req, 1'b0);
    tick;
    chk("misfetch_halt", halted, 1'b1);
    chk("misfetch_cause", trap_cause, 2'b01);
    tick;
    chk("trap_pc_frozen", pc, 32'h042);
    chk("trap_req", mem_req, 1'b0);
    chk("trap_rw", reg_write, 1'b0);

    // Misaligned half store
    reset_dut;
    to_exec(32'h100, 32'h0020_9023);
    alu_result = 32'h205;
    tick;
    tick;
    chk("mis_sh_halt", halted, 1'b1);
    chk("mis_sh_cause", trap_cause, 2'b10);
    chk("mis_sh_we", mem_we, 1'b0);

    // Illegal opcode
    reset_dut;
    fetch(32'h100, 32'hFFFF_FFFF, 0);
    tick;
    chk("illegal_halt", halted, 1'b1);
    chk("illegal_cause", trap_cause, 2'b11);

    // Fetch timeout: 15 waiting cycles then trap
    reset_dut;
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("to_wait_req", mem_req, 1'b1);
      chk("to_wait_halt", halted, 1'b0);
      tick;
    end
    chk("to_halt", halted, 1'b1);
    chk("to_cause", trap_cause, 2'b11);
    chk("to_req", mem_req, 1'b0);

    // Reset in the middle of an outstanding MEM request
    reset_dut;
    to_exec(32'h100, 32'h0001_0083);
    alu_result = 32'h300;
    tick;
    tick;
    tick;
    chk("midmem_req", mem_req, 1'b1);
    chk("midmem_addr", mem_addr, 32'h300);
    reset = 1'b1;
    #1;
    chk("rst_mid_req", mem_req, 1'b0);
    chk("rst_mid_pc", pc, 32'h100);
    chk("rst_mid_halt", halted, 1'b0);
    tick;
    reset = 1'b0;
    #1;
    chk("rst_mid_idle", mem_req, 1'b0);
    tick;
    chk("rst_mid_fetch", mem_addr, 32'h100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
